// File: rtl/lc3_addr_pkg.sv
// Shared types and reset constants for the LC-3 address-generation stage.
package lc3_addr_pkg;

  typedef enum logic [1:0] {
    PCMUX_INC  = 2'b00,
    PCMUX_BUS  = 2'b01,
    PCMUX_ADDR = 2'b10,
    PCMUX_RSVD = 2'b11
  } pcmux_e;

  typedef enum logic {
    ADDR1_PC    = 1'b0,
    ADDR1_BASER = 1'b1
  } addr1mux_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO = 2'b00,
    ADDR2_OFF6 = 2'b01,
    ADDR2_OFF9 = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2mux_e;

  typedef enum logic {
    MARMUX_BUS  = 1'b0,
    MARMUX_ADDR = 1'b1
  } marmux_e;

  localparam logic [15:0] PC_RESET_VAL  = 16'h0000;
  localparam logic [15:0] MAR_RESET_VAL = 16'h0000;
  localparam logic [2:0]  NZP_RESET_VAL = 3'b010;

endpackage

// File: rtl/pc_addr_unit_nzp_ben.sv
// Condition-code register and branch-enable flag; BEN always samples the
// registered NZP, so a same-cycle CC load is not seen until the next cycle.
module nzp_ben_unit import lc3_addr_pkg::*; #(
  parameter logic [2:0] NZP_RESET = NZP_RESET_VAL
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Bus,
  input  logic        LD_CC,
  input  logic        LD_BEN,
  input  logic [2:0]  ir_cond,
  output logic [2:0]  NZP,
  output logic        BEN
);

  logic       cc_n;
  logic       cc_z;
  logic [2:0] cc_next;
  logic       ben_next;

  assign cc_n     = Bus[15];
  assign cc_z     = (Bus == 16'h0000);
  assign cc_next  = {cc_n, cc_z, ~cc_n & ~cc_z};
  assign ben_next = |(ir_cond & NZP);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      NZP <= NZP_RESET;
      BEN <= 1'b0;
    end else begin
      if (LD_CC)  NZP <= cc_next;
      if (LD_BEN) BEN <= ben_next;
    end
  end

endmodule

// File: rtl/sext.sv
// Sign-extends an IW-bit immediate field to a 16-bit datapath word.
module sext #(
  parameter int IW = 6
) (
  input  logic [IW-1:0] field,
  output logic [15:0]   value
);

  assign value = {{(16-IW){field[IW-1]}}, field};

endmodule

// File: rtl/pc_addr_unit.sv
// LC-3 PC / MAR / effective-address stage: offset adder, PC and MAR
// registers, and the condition-code / branch-enable sub-unit.
module pc_addr_unit import lc3_addr_pkg::*; #(
  parameter logic [15:0] PC_RESET  = PC_RESET_VAL,
  parameter logic [2:0]  NZP_RESET = NZP_RESET_VAL
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IR,
  input  logic [15:0] BaseR,
  input  logic [15:0] Bus,
  input  logic        LD_PC,
  input  logic        LD_MAR,
  input  logic        LD_CC,
  input  logic        LD_BEN,
  input  logic [1:0]  PCMUX,
  input  logic        ADDR1MUX,
  input  logic [1:0]  ADDR2MUX,
  input  logic        MARMUX,
  output logic [15:0] PC,
  output logic [15:0] MAR,
  output logic [15:0] ADDR_OUT,
  output logic [2:0]  NZP,
  output logic        BEN
);

  logic [15:0] off6;
  logic [15:0] off9;
  logic [15:0] off11;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] pc_next;
  logic [15:0] mar_next;
  logic        unused_ir;

  // Opcode bits are decoded by the control FSM, not here.
  assign unused_ir = ^IR[15:12];

  sext #(.IW(6))  u_sext6  (.field(IR[5:0]),  .value(off6));
  sext #(.IW(9))  u_sext9  (.field(IR[8:0]),  .value(off9));
  sext #(.IW(11)) u_sext11 (.field(IR[10:0]), .value(off11));

  always_comb begin
    op_a = (addr1mux_e'(ADDR1MUX) == ADDR1_BASER) ? BaseR : PC;
    op_b = 16'h0000;
    case (addr2mux_e'(ADDR2MUX))
      ADDR2_ZERO:  op_b = 16'h0000;
      ADDR2_OFF6:  op_b = off6;
      ADDR2_OFF9:  op_b = off9;
      ADDR2_OFF11: op_b = off11;
      default:     op_b = 16'h0000;
    endcase
  end

  assign ADDR_OUT = op_a + op_b;

  always_comb begin
    pc_next = PC;
    case (pcmux_e'(PCMUX))
      PCMUX_INC:  pc_next = PC + 16'h0001;
      PCMUX_BUS:  pc_next = Bus;
      PCMUX_ADDR: pc_next = ADDR_OUT;
      default:    pc_next = PC;
    endcase
  end

  assign mar_next = (marmux_e'(MARMUX) == MARMUX_ADDR) ? ADDR_OUT : Bus;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC  <= PC_RESET;
      MAR <= MAR_RESET_VAL;
    end else begin
      if (LD_PC)  PC  <= pc_next;
      if (LD_MAR) MAR <= mar_next;
    end
  end

  nzp_ben_unit #(.NZP_RESET(NZP_RESET)) u_nzp_ben (
    .Clk     (Clk),
    .Reset   (Reset),
    .Bus     (Bus),
    .LD_CC   (LD_CC),
    .LD_BEN  (LD_BEN),
    .ir_cond (IR[11:9]),
    .NZP     (NZP),
    .BEN     (BEN)
  );

endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed bench for pc_addr_unit with hand-computed expectations.
module tb_pc_addr_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IR, BaseR, Bus;
  logic        LD_PC, LD_MAR, LD_CC, LD_BEN;
  logic [1:0]  PCMUX, ADDR2MUX;
  logic        ADDR1MUX, MARMUX;
  logic [15:0] PC, MAR, ADDR_OUT;
  logic [2:0]  NZP;
  logic        BEN;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  pc_addr_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .BaseR(BaseR), .Bus(Bus),
    .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX),
    .PC(PC), .MAR(MAR), .ADDR_OUT(ADDR_OUT), .NZP(NZP), .BEN(BEN)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    LD_PC = 0; LD_MAR = 0; LD_CC = 0; LD_BEN = 0;
  endtask

  // Apply the current strobes across one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
    idle();
  endtask

  initial begin
    Reset = 1; IR = 16'h0000; BaseR = 16'h0000; Bus = 16'h0000;
    PCMUX = 2'b00; ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; MARMUX = 1'b0;
    idle();
    #2;
    check("rst_pc", PC, 16'h0000);
    check("rst_mar", MAR, 16'h0000);
    check("rst_nzp", {13'd0, NZP}, 16'h0002);
    check("rst_ben", {15'd0, BEN}, 16'h0000);
    check("rst_addr", ADDR_OUT, 16'h0000);
    @(negedge Clk); Reset = 0;

    // Bus into PC and MAR in the same cycle
    Bus = 16'h1234; PCMUX = 2'b01; MARMUX = 1'b0; LD_PC = 1; LD_MAR = 1;
    tick();
    check("bus_pc", PC, 16'h1234);
    check("bus_mar", MAR, 16'h1234);

    // Positive CC, then BEN on P
    LD_CC = 1; tick();
    check("cc_pos", {13'd0, NZP}, 16'h0001);
    IR = 16'h0200; LD_BEN = 1; tick();
    check("ben_set", {15'd0, BEN}, 16'h0001);

    // No loads: everything holds
    Bus = 16'h8000; tick();
    check("hold_pc", PC, 16'h1234);
    check("hold_nzp", {13'd0, NZP}, 16'h0001);

    // Asynchronous reset mid-cycle
    #3; Reset = 1; #1;
    check("arst_pc", PC, 16'h0000);
    check("arst_mar", MAR, 16'h0000);
    check("arst_nzp", {13'd0, NZP}, 16'h0002);
    check("arst_ben", {15'd0, BEN}, 16'h0000);
    @(negedge Clk); Reset = 0;

    // PC+1 wraps
    Bus = 16'hFFFF; PCMUX = 2'b01; LD_PC = 1; tick();
    check("pc_ffff", PC, 16'hFFFF);
    PCMUX = 2'b00; LD_PC = 1; tick();
    check("pc_wrap", PC, 16'h0000);
    LD_PC = 1; tick();
    check("pc_inc", PC, 16'h0001);

    // Reserved PCMUX holds PC
    PCMUX = 2'b11; LD_PC = 1; tick();
    check("pc_rsvd", PC, 16'h0001);

    // PC-relative branch target, captured by PC and MAR together
    Bus = 16'h3000; PCMUX = 2'b01; LD_PC = 1; tick();
    IR = 16'h01FE; ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; #1;
    check("addr_off9", ADDR_OUT, 16'h2FFE);
    PCMUX = 2'b10; MARMUX = 1'b1; LD_PC = 1; LD_MAR = 1; tick();
    check("br_pc", PC, 16'h2FFE);
    check("br_mar", MAR, 16'h2FFE);

    // Base + offset6 into MAR
    BaseR = 16'h4000; IR = 16'h003F; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; #1;
    check("addr_off6", ADDR_OUT, 16'h3FFF);
    MARMUX = 1'b1; LD_MAR = 1; tick();
    check("mar_off6", MAR, 16'h3FFF);

    // Offset11 and zero operand
    IR = 16'h0400; ADDR2MUX = 2'b11; #1;
    check("addr_off11", ADDR_OUT, 16'h3C00);
    ADDR2MUX = 2'b00; #1;
    check("addr_zero", ADDR_OUT, 16'h4000);
    ADDR1MUX = 1'b0; IR = 16'h07FF; ADDR2MUX = 2'b11; #1;
    check("addr_pc_m1", ADDR_OUT, 16'h2FFD);

    // CC sequence
    Bus = 16'h8000; LD_CC = 1; tick();
    check("cc_neg", {13'd0, NZP}, 16'h0004);
    Bus = 16'h0000; LD_CC = 1; tick();
    check("cc_zero", {13'd0, NZP}, 16'h0002);
    Bus = 16'h0001; LD_CC = 1; tick();
    check("cc_p", {13'd0, NZP}, 16'h0001);

    // LD_CC and LD_BEN together: BEN sees old NZP
    IR = 16'h0200; Bus = 16'h0000; LD_CC = 1; LD_BEN = 1; tick();
    check("ben_old", {15'd0, BEN}, 16'h0001);
    check("nzp_new", {13'd0, NZP}, 16'h0002);
    LD_BEN = 1; tick();
    check("ben_new", {15'd0, BEN}, 16'h0000);
    IR = 16'h0E00; LD_BEN = 1; tick();
    check("ben_nzp", {15'd0, BEN}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
